// File: rtl/add_rs.sv
// add_rs: reservation station in front of the two-cycle add/sub unit.
// Holds dispatched ops until both operands arrive via the CDB, then issues one at a time.
module add_rs #(
    parameter int unsigned NUM_RS   = 4,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned TAG_BASE = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [2:0]        disp_op,
    input  logic [31:0]       disp_vj,
    input  logic [31:0]       disp_vk,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [TAG_W-1:0]  disp_qk,
    output logic [TAG_W-1:0]  disp_tag,

    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [31:0]       cdb_data,

    output logic              exe_start,
    output logic [2:0]        exe_op,
    output logic [31:0]       exe_a,
    output logic [31:0]       exe_b,
    input  logic              exe_valid,
    input  logic [31:0]       exe_result,

    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [31:0]       wb_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned IDX_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
    } entry_t;

    state_e              state_q, state_d;
    logic [NUM_RS-1:0]   busy_q, busy_d;
    logic [NUM_RS-1:0]   issued_q, issued_d;
    entry_t              ent_q [NUM_RS];
    entry_t              ent_d [NUM_RS];
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                exe_start_q, exe_start_d;
    logic [OP_W-1:0]     exe_op_q, exe_op_d;
    logic [DATA_W-1:0]   exe_a_q, exe_a_d;
    logic [DATA_W-1:0]   exe_b_q, exe_b_d;
    logic                wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]    wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;

    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic                rdy_found;
    logic [IDX_W-1:0]    rdy_idx;
    logic                disp_fire;
    logic                issue_fire;
    logic                done_fire;
    logic                cdb_hit_j;
    logic                cdb_hit_k;

    // Lowest-index free entry; drives dispatch handshake from registered busy bits only.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(NUM_RS); i++) begin
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign disp_ready = free_found;
    assign disp_tag   = free_found ? (TAG_W'(TAG_BASE) + TAG_W'(free_idx)) : '0;
    assign disp_fire  = disp_valid && free_found;

    // Lowest-index entry with both operands present and not yet sent to the adder.
    always_comb begin
        rdy_found = 1'b0;
        rdy_idx   = '0;
        for (int i = 0; i < int'(NUM_RS); i++) begin
            if (!rdy_found && busy_q[i] && !issued_q[i]
                && (ent_q[i].qj == '0) && (ent_q[i].qk == '0)) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
        end
    end

    // Issue FSM: one operation in flight; result returned as a wb pulse.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        exe_start_d = 1'b0;
        exe_op_d    = exe_op_q;
        exe_a_d     = exe_a_q;
        exe_b_d     = exe_b_q;
        wb_valid_d  = 1'b0;
        wb_tag_d    = wb_tag_q;
        wb_data_d   = wb_data_q;
        issue_fire  = 1'b0;
        done_fire   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rdy_found) begin
                    state_d     = ST_WAIT;
                    idx_d       = rdy_idx;
                    exe_start_d = 1'b1;
                    exe_op_d    = ent_q[rdy_idx].op;
                    exe_a_d     = ent_q[rdy_idx].vj;
                    exe_b_d     = ent_q[rdy_idx].vk;
                    issue_fire  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (exe_valid) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_tag_d   = TAG_W'(TAG_BASE) + TAG_W'(idx_q);
                    wb_data_d  = exe_result;
                    done_fire  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cdb_hit_j = cdb_valid && (cdb_tag != '0) && (cdb_tag == disp_qj);
    assign cdb_hit_k = cdb_valid && (cdb_tag != '0) && (cdb_tag == disp_qk);

    // Entry updates: CDB snoop, issue marking, completion free, dispatch write with bypass.
    always_comb begin
        busy_d   = busy_q;
        issued_d = issued_q;
        ent_d    = ent_q;
        for (int i = 0; i < int'(NUM_RS); i++) begin
            if (busy_q[i] && cdb_valid && (cdb_tag != '0)) begin
                if (ent_q[i].qj == cdb_tag) begin
                    ent_d[i].vj = cdb_data;
                    ent_d[i].qj = '0;
                end
                if (ent_q[i].qk == cdb_tag) begin
                    ent_d[i].vk = cdb_data;
                    ent_d[i].qk = '0;
                end
            end
            if (issue_fire && (rdy_idx == IDX_W'(i))) begin
                issued_d[i] = 1'b1;
            end
            if (done_fire && (idx_q == IDX_W'(i))) begin
                busy_d[i]   = 1'b0;
                issued_d[i] = 1'b0;
            end
            if (disp_fire && (free_idx == IDX_W'(i))) begin
                busy_d[i]    = 1'b1;
                issued_d[i]  = 1'b0;
                ent_d[i].op  = disp_op;
                ent_d[i].vj  = cdb_hit_j ? cdb_data : disp_vj;
                ent_d[i].qj  = cdb_hit_j ? '0 : disp_qj;
                ent_d[i].vk  = cdb_hit_k ? cdb_data : disp_vk;
                ent_d[i].qk  = cdb_hit_k ? '0 : disp_qk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= '0;
            issued_q    <= '0;
            idx_q       <= '0;
            exe_start_q <= 1'b0;
            exe_op_q    <= '0;
            exe_a_q     <= '0;
            exe_b_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_tag_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            issued_q    <= issued_d;
            idx_q       <= idx_d;
            exe_start_q <= exe_start_d;
            exe_op_q    <= exe_op_d;
            exe_a_q     <= exe_a_d;
            exe_b_q     <= exe_b_d;
            wb_valid_q  <= wb_valid_d;
            wb_tag_q    <= wb_tag_d;
            wb_data_q   <= wb_data_d;
        end
    end

    // Payloads are qualified by busy, so they need no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign exe_start = exe_start_q;
    assign exe_op    = exe_op_q;
    assign exe_a     = exe_a_q;
    assign exe_b     = exe_b_q;
    assign wb_valid  = wb_valid_q;
    assign wb_tag    = wb_tag_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_add_rs.sv
// tb_add_rs: directed scenarios plus randomized traffic checked against a station model.
module tb_add_rs;

    localparam int unsigned NUM_RS   = 4;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned TAG_BASE = 1;

    logic              clk;
    logic              rst_n;
    logic              disp_valid;
    logic              disp_ready;
    logic [2:0]        disp_op;
    logic [31:0]       disp_vj;
    logic [31:0]       disp_vk;
    logic [TAG_W-1:0]  disp_qj;
    logic [TAG_W-1:0]  disp_qk;
    logic [TAG_W-1:0]  disp_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_data;
    logic              exe_start;
    logic [2:0]        exe_op;
    logic [31:0]       exe_a;
    logic [31:0]       exe_b;
    logic              exe_valid;
    logic [31:0]       exe_result;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [31:0]       wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    add_rs #(.NUM_RS(NUM_RS), .TAG_W(TAG_W), .TAG_BASE(TAG_BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .exe_start(exe_start), .exe_op(exe_op), .exe_a(exe_a), .exe_b(exe_b),
        .exe_valid(exe_valid), .exe_result(exe_result),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: what the station should hold and present after each edge.
    bit [NUM_RS-1:0]  m_busy;
    bit [NUM_RS-1:0]  m_iss;
    logic [2:0]       m_op [NUM_RS];
    logic [31:0]      m_vj [NUM_RS];
    logic [31:0]      m_vk [NUM_RS];
    logic [TAG_W-1:0] m_qj [NUM_RS];
    logic [TAG_W-1:0] m_qk [NUM_RS];
    bit               m_wait;
    int               m_idx;
    bit               m_start;
    bit               m_wbv;
    logic [2:0]       m_eop;
    logic [31:0]      m_ea, m_eb, m_wbd;
    logic [TAG_W-1:0] m_wbt;

    function automatic void mdl_reset();
        m_busy = '0; m_iss = '0; m_wait = 1'b0; m_idx = 0;
        m_start = 1'b0; m_wbv = 1'b0; m_eop = '0;
        m_ea = '0; m_eb = '0; m_wbt = '0; m_wbd = '0;
    endfunction

    function automatic void model_edge();
        int fr;
        int rd;
        bit [NUM_RS-1:0] held;
        if (!rst_n) begin
            mdl_reset();
            return;
        end
        fr = -1;
        rd = -1;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!m_busy[i]) fr = i;
            if (m_busy[i] && !m_iss[i] && m_qj[i] == 0 && m_qk[i] == 0) rd = i;
        end
        held    = m_busy;
        m_start = 1'b0;
        m_wbv   = 1'b0;
        if (!m_wait) begin
            if (rd >= 0) begin
                m_start = 1'b1;
                m_eop = m_op[rd]; m_ea = m_vj[rd]; m_eb = m_vk[rd];
                m_iss[rd] = 1'b1; m_idx = rd; m_wait = 1'b1;
            end
        end else if (exe_valid) begin
            m_wbv = 1'b1;
            m_wbt = TAG_W'(TAG_BASE + m_idx);
            m_wbd = exe_result;
            m_busy[m_idx] = 1'b0; m_iss[m_idx] = 1'b0; m_wait = 1'b0;
        end
        for (int i = 0; i < NUM_RS; i++) begin
            if (held[i] && cdb_valid && cdb_tag != 0) begin
                if (m_qj[i] == cdb_tag) begin m_vj[i] = cdb_data; m_qj[i] = '0; end
                if (m_qk[i] == cdb_tag) begin m_vk[i] = cdb_data; m_qk[i] = '0; end
            end
        end
        if (disp_valid && fr >= 0) begin
            m_busy[fr] = 1'b1; m_iss[fr] = 1'b0; m_op[fr] = disp_op;
            if (cdb_valid && cdb_tag != 0 && cdb_tag == disp_qj) begin
                m_vj[fr] = cdb_data; m_qj[fr] = '0;
            end else begin
                m_vj[fr] = disp_vj; m_qj[fr] = disp_qj;
            end
            if (cdb_valid && cdb_tag != 0 && cdb_tag == disp_qk) begin
                m_vk[fr] = cdb_data; m_qk[fr] = '0;
            end else begin
                m_vk[fr] = disp_vk; m_qk[fr] = disp_qk;
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid = 1'b0; disp_op = '0; disp_vj = '0; disp_vk = '0;
        disp_qj = '0; disp_qk = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        exe_valid = 1'b0; exe_result = '0;
    endtask

    task automatic dispatch(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk);
        disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk; disp_qj = qj; disp_qk = qk;
        cyc();
        disp_valid = 1'b0; disp_qj = '0; disp_qk = '0;
    endtask

    task automatic pulse_exe(input logic [31:0] res);
        exe_valid = 1'b1; exe_result = res;
        cyc();
        exe_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        mdl_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL rst_disp_ready got %0b want 1", disp_ready); end
        n_tests++; if (disp_tag !== 4'd1) begin n_fail++; $display("FAIL rst_disp_tag got %0d want 1", disp_tag); end
        n_tests++; if (exe_start !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got start=%0b wb=%0b want 0/0", exe_start, wb_valid); end
        n_tests++; if (exe_a !== 32'd0 || exe_b !== 32'd0 || wb_data !== 32'd0 || wb_tag !== 4'd0) begin n_fail++; $display("FAIL rst_regs got a=%0h b=%0h wbd=%0h wbt=%0h want 0", exe_a, exe_b, wb_data, wb_tag); end
        dispatch(3'd0, 32'd3, 32'd4, '0, '0);
        cyc();
        n_tests++; if (exe_start !== 1'b1) begin n_fail++; $display("FAIL rst_pre_issue got %0b want 1", exe_start); end
        cyc();
        #3;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        n_tests++; if (exe_start !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_pulses got start=%0b wb=%0b want 0/0", exe_start, wb_valid); end
        n_tests++; if (disp_ready !== 1'b1 || disp_tag !== 4'd1) begin n_fail++; $display("FAIL rst_async_free got rdy=%0b tag=%0d want 1/1", disp_ready, disp_tag); end
        n_tests++; if (exe_a !== 32'd0 || exe_op !== 3'd0) begin n_fail++; $display("FAIL rst_async_exe got a=%0h op=%0d want 0/0", exe_a, exe_op); end
        cyc();
        rst_n = 1'b1;
        pulse_exe(32'h55);
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_wb got %0b want 0", wb_valid); end
    endtask

    task automatic test_ready_add();
        do_reset();
        dispatch(3'd0, 32'd5, 32'd7, '0, '0);
        n_tests++; if (exe_start !== 1'b0) begin n_fail++; $display("FAIL add_k1_start got %0b want 0", exe_start); end
        cyc();
        n_tests++; if (exe_start !== 1'b1 || exe_a !== 32'd5 || exe_b !== 32'd7 || exe_op !== 3'd0) begin n_fail++; $display("FAIL add_issue got s=%0b a=%0d b=%0d op=%0d want 1/5/7/0", exe_start, exe_a, exe_b, exe_op); end
        cyc();
        n_tests++; if (exe_start !== 1'b0) begin n_fail++; $display("FAIL add_single_start got %0b want 0", exe_start); end
        pulse_exe(32'd12);
        n_tests++; if (wb_valid !== 1'b1 || wb_tag !== 4'd1 || wb_data !== 32'd12) begin n_fail++; $display("FAIL add_wb got v=%0b t=%0d d=%0d want 1/1/12", wb_valid, wb_tag, wb_data); end
        n_tests++; if (disp_ready !== 1'b1 || disp_tag !== 4'd1) begin n_fail++; $display("FAIL add_freed got rdy=%0b tag=%0d want 1/1", disp_ready, disp_tag); end
        cyc();
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_wb_pulse got %0b want 0", wb_valid); end
    endtask

    task automatic test_pending();
        do_reset();
        dispatch(3'd1, 32'd20, 32'd0, '0, 4'd3);
        cyc();
        n_tests++; if (exe_start !== 1'b0) begin n_fail++; $display("FAIL pend_no_issue got %0b want 0", exe_start); end
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'd8;
        cyc();
        cdb_valid = 1'b0;
        n_tests++; if (exe_start !== 1'b0) begin n_fail++; $display("FAIL pend_c1 got %0b want 0", exe_start); end
        cyc();
        n_tests++; if (exe_start !== 1'b1 || exe_a !== 32'd20 || exe_b !== 32'd8 || exe_op !== 3'd1) begin n_fail++; $display("FAIL pend_issue got s=%0b a=%0d b=%0d op=%0d want 1/20/8/1", exe_start, exe_a, exe_b, exe_op); end
        cyc();
        pulse_exe(32'd12);
        n_tests++; if (wb_valid !== 1'b1 || wb_tag !== 4'd1 || wb_data !== 32'd12) begin n_fail++; $display("FAIL pend_wb got v=%0b t=%0d d=%0d want 1/1/12", wb_valid, wb_tag, wb_data); end
    endtask

    task automatic test_bypass_full();
        do_reset();
        n_tests++; if (disp_tag !== 4'd1) begin n_fail++; $display("FAIL full_tag0 got %0d want 1", disp_tag); end
        dispatch(3'd0, 32'd0, 32'd0, 4'd12, '0);
        n_tests++; if (disp_tag !== 4'd2) begin n_fail++; $display("FAIL full_tag1 got %0d want 2", disp_tag); end
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'hFFFF_FFFF;
        dispatch(3'd0, 32'd0, 32'd1, 4'd9, '0);
        cdb_valid = 1'b0;
        n_tests++; if (disp_tag !== 4'd3) begin n_fail++; $display("FAIL full_tag2 got %0d want 3", disp_tag); end
        dispatch(3'd0, 32'd0, 32'd0, '0, 4'd13);
        n_tests++; if (exe_start !== 1'b1 || exe_a !== 32'hFFFF_FFFF || exe_b !== 32'd1) begin n_fail++; $display("FAIL bypass_issue got s=%0b a=%0h b=%0h want 1/ffffffff/1", exe_start, exe_a, exe_b); end
        n_tests++; if (disp_tag !== 4'd4) begin n_fail++; $display("FAIL full_tag3 got %0d want 4", disp_tag); end
        dispatch(3'd0, 32'd0, 32'd0, 4'd14, '0);
        n_tests++; if (disp_ready !== 1'b0 || disp_tag !== 4'd0) begin n_fail++; $display("FAIL full_flag got rdy=%0b tag=%0d want 0/0", disp_ready, disp_tag); end
        dispatch(3'd0, 32'd1, 32'd1, '0, '0);
        n_tests++; if (disp_ready !== 1'b0 || disp_tag !== 4'd0) begin n_fail++; $display("FAIL full_ignored got rdy=%0b tag=%0d want 0/0", disp_ready, disp_tag); end
        pulse_exe(32'd0);
        n_tests++; if (wb_valid !== 1'b1 || wb_tag !== 4'd2 || disp_tag !== 4'd2) begin n_fail++; $display("FAIL full_free got v=%0b wbt=%0d dtag=%0d want 1/2/2", wb_valid, wb_tag, disp_tag); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++; if (exe_start !== 1'b0) begin n_fail++; $display("FAIL full_no_extra cyc=%0d got %0b want 0", i, exe_start); end
        end
    endtask

    task automatic test_ordering();
        do_reset();
        dispatch(3'd0, 32'd0, 32'd3, 4'd10, '0);
        dispatch(3'd0, 32'd0, 32'd0, 4'd11, '0);
        dispatch(3'd1, 32'd50, 32'd0, '0, 4'd10);
        cdb_valid = 1'b1; cdb_tag = 4'd10; cdb_data = 32'd100;
        cyc();
        cdb_valid = 1'b0;
        n_tests++; if (exe_start !== 1'b0) begin n_fail++; $display("FAIL ord_c1 got %0b want 0", exe_start); end
        cyc();
        n_tests++; if (exe_start !== 1'b1 || exe_a !== 32'd100 || exe_b !== 32'd3 || exe_op !== 3'd0) begin n_fail++; $display("FAIL ord_first got s=%0b a=%0d b=%0d op=%0d want 1/100/3/0", exe_start, exe_a, exe_b, exe_op); end
        pulse_exe(32'd103);
        n_tests++; if (wb_valid !== 1'b1 || wb_tag !== 4'd1 || wb_data !== 32'd103 || exe_start !== 1'b0) begin n_fail++; $display("FAIL ord_wb1 got v=%0b t=%0d d=%0d s=%0b want 1/1/103/0", wb_valid, wb_tag, wb_data, exe_start); end
        cyc();
        n_tests++; if (exe_start !== 1'b1 || exe_a !== 32'd50 || exe_b !== 32'd100 || exe_op !== 3'd1) begin n_fail++; $display("FAIL ord_second got s=%0b a=%0d b=%0d op=%0d want 1/50/100/1", exe_start, exe_a, exe_b, exe_op); end
        pulse_exe(32'hFFFF_FFCE);
        n_tests++; if (wb_valid !== 1'b1 || wb_tag !== 4'd3 || wb_data !== 32'hFFFF_FFCE) begin n_fail++; $display("FAIL ord_wb2 got v=%0b t=%0d d=%0h want 1/3/ffffffce", wb_valid, wb_tag, wb_data); end
    endtask

    task automatic test_spurious();
        do_reset();
        dispatch(3'd0, 32'd1, 32'd2, 4'd7, '0);
        pulse_exe(32'd99);
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL spur_wb got %0b want 0", wb_valid); end
        n_tests++; if (disp_tag !== 4'd2) begin n_fail++; $display("FAIL spur_kept got %0d want 2", disp_tag); end
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'd40;
        cyc();
        cdb_valid = 1'b0;
        cyc();
        n_tests++; if (exe_start !== 1'b1 || exe_a !== 32'd40 || exe_b !== 32'd2) begin n_fail++; $display("FAIL spur_alive got s=%0b a=%0d b=%0d want 1/40/2", exe_start, exe_a, exe_b); end
    endtask

    task automatic test_random();
        int lat;
        int r;
        lat = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            n_tests++; if (disp_ready !== (m_busy != '1)) begin n_fail++; $display("FAIL rnd_ready c=%0d got %0b", c, disp_ready); end
            n_tests++; if (exe_start !== m_start) begin n_fail++; $display("FAIL rnd_start c=%0d got %0b want %0b", c, exe_start, m_start); end
            n_tests++; if (exe_op !== m_eop || exe_a !== m_ea || exe_b !== m_eb) begin n_fail++; $display("FAIL rnd_exe c=%0d got %0d/%h/%h want %0d/%h/%h", c, exe_op, exe_a, exe_b, m_eop, m_ea, m_eb); end
            n_tests++; if (wb_valid !== m_wbv) begin n_fail++; $display("FAIL rnd_wbv c=%0d got %0b want %0b", c, wb_valid, m_wbv); end
            n_tests++; if (wb_tag !== m_wbt || wb_data !== m_wbd) begin n_fail++; $display("FAIL rnd_wb c=%0d got %0d/%h want %0d/%h", c, wb_tag, wb_data, m_wbt, m_wbd); end
            begin
                logic [TAG_W-1:0] exp_tag;
                exp_tag = '0;
                for (int i = NUM_RS - 1; i >= 0; i--) if (!m_busy[i]) exp_tag = TAG_W'(TAG_BASE + i);
                n_tests++; if (disp_tag !== exp_tag) begin n_fail++; $display("FAIL rnd_dtag c=%0d got %0d want %0d", c, disp_tag, exp_tag); end
            end
            exe_valid = 1'b0;
            if (m_start) lat = $urandom_range(1, 3);
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    exe_valid  = 1'b1;
                    exe_result = (m_eop == 3'd1) ? (m_ea - m_eb) : (m_ea + m_eb);
                end
            end else if (!m_wait && $urandom_range(0, 15) == 0) begin
                exe_valid  = 1'b1;
                exe_result = $urandom;
            end
            disp_valid = ($urandom_range(0, 1) == 1);
            disp_op    = 3'($urandom_range(0, 7));
            disp_vj    = $urandom;
            disp_vk    = $urandom;
            r = $urandom_range(0, 3);
            disp_qj    = (r < 2) ? '0 : TAG_W'($urandom_range(1, 6));
            r = $urandom_range(0, 3);
            disp_qk    = (r < 2) ? '0 : TAG_W'($urandom_range(1, 6));
            cdb_valid  = ($urandom_range(0, 2) == 0);
            cdb_tag    = TAG_W'($urandom_range(0, 6));
            cdb_data   = $urandom;
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        mdl_reset();
        test_reset();
        test_ready_add();
        test_pending();
        test_bypass_full();
        test_ordering();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/add_rs.md
# add_rs

Reservation station that feeds the two-cycle add/subtract execution unit. It accepts dispatched add/sub instructions whose operands may still be pending, and snoops the common data bus (CDB) for tagged results. It issues one operand-ready instruction at a time to the adder over a start/valid handshake, then presents the adder's result with the issuing entry's tag as a one-cycle writeback pulse.

## Interface
- NUM_RS, 4: number of entries (2..8).
- TAG_W, 4: tag width. Tag value 0 means "operand value valid".
- TAG_BASE, 1: tag of entry 0. Entry i owns tag TAG_BASE+i. TAG_BASE ≥ 1 and TAG_BASE+NUM_RS-1 < 2^TAG_W.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry; combinational from registered busy bits.
- disp_op  in  3  0 = add, 1 = sub; other codes are stored and forwarded unchanged.
- disp_vj, disp_vk  in  32  operand values.
- disp_qj, disp_qk  in  TAG_W  producer tags; 0 = value valid.
- disp_tag  out  TAG_W  tag of the entry the next dispatch will occupy (lowest-index free entry); 0 when full.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB tag.
- cdb_data  in  32  CDB value.
- exe_start  out  1  one-cycle issue pulse to the adder; registered.
- exe_op  out  3  registered; held until the next issue.
- exe_a, exe_b  out  32  registered; held until the next issue.
- exe_valid  in  1  adder completion pulse.
- exe_result  in  32  adder result, sampled when exe_valid is high.
- wb_valid  out  1  one-cycle result pulse; registered.
- wb_tag  out  TAG_W  tag of the completed entry; registered.
- wb_data  out  32  completed value; registered.

## Operation
- Each entry holds: busy, issued, op, vj, qj, vk, qk.
- **Dispatch:** on disp_valid && disp_ready, write the lowest-index free entry with busy=1 and issued=0.
  - Same-cycle CDB bypass: if cdb_valid and cdb_tag == disp_qj ≠ 0, store vj=cdb_data and qj=0. The same rule applies to k.
  - disp_valid while full is ignored; nothing is written.
- **Snoop:** every busy entry with qj == cdb_tag ≠ 0 captures cdb_data into vj and clears qj. Same for k. cdb_tag 0 never matches.
- **Ready entry:** busy && !issued && qj==0 && qk==0, evaluated on registered state.
- **Issue FSM**, states IDLE and WAIT:
  - IDLE: if any entry is ready, select the lowest-index ready entry. Register exe_start=1, exe_op/exe_a/exe_b from that entry, set its issued bit, latch its index, go to WAIT. Otherwise stay in IDLE with exe_start=0.
  - WAIT: exe_start=0. On exe_valid: register wb_valid=1, wb_tag=TAG_BASE+index, wb_data=exe_result; clear busy and issued of that entry; go to IDLE.
  - exe_valid in IDLE is ignored.
- Only one operation is in flight at a time. No backpressure on wb.
- The block has no own-tag CDB loopback. wb is routed to the CDB externally, which then updates other entries through the normal snoop.
- **Reset (async, any time, including during WAIT):** all busy and issued bits = 0, state = IDLE, exe_start = 0, wb_valid = 0. exe_op, exe_a, exe_b, wb_tag and wb_data = 0. Entry payloads are don't-care.

## Timing
- Dispatch accepted at edge k → entry visible in cycle k+1.
- If both operands are ready at dispatch (or bypassed), exe_start is high in cycle k+2.
- CDB capture at edge c → the entry can issue at the earliest in cycle c+2.
- exe_valid sampled at edge m → wb_valid high in cycle m+1 for exactly one cycle.
  - The entry is free in cycle m+1, so disp_ready and disp_tag reflect it then.
  - The next exe_start is at the earliest in cycle m+2.
- disp_ready and disp_tag do not anticipate same-cycle frees.

## Test plan
- **Reset:** assert rst_n=0 mid-WAIT, asynchronously → exe_start=0, wb_valid=0, disp_ready=1, disp_tag=1 immediately.
- **Ready add:** dispatch op=0, vj=5, vk=7, q=0 at edge k → exe_start in cycle k+2 with a=5, b=7. Return exe_valid with result 12 → wb_valid=1, wb_tag=1, wb_data=12 one cycle later.
- **Pending operand:**
  - Dispatch op=1, vj=20, qk=3 → no exe_start.
  - cdb_valid, tag=3, data=8 → exe_start two cycles later with a=20, b=8.
  - wb_data=12 after the adder returns.
- **Bypass and full:**
  - Dispatch 4 entries; the 2nd has qj=9 while cdb_valid, cdb_tag=9, cdb_data=0xFFFF_FFFF in the same cycle → entry captures vj=0xFFFF_FFFF.
  - After the 4th dispatch, disp_ready=0 and disp_tag=0; a 5th disp_valid is ignored.
- **Ordering:** entries 2 and 0 become ready in the same cycle → entry 0 issues first. Entry 2 issues at m+2 after entry 0's exe_valid at edge m. wb_tags are 1 then 3.
- **Spurious completion:** exe_valid pulsed in IDLE → no wb_valid, no entry freed.
